sha3_absorb_pack: RTL and testbench

- Read-side consumer of the dual-clock message FIFO; lives in the FIFO read-clock domain.
- Pulls 32-bit message words with a get/valid handshake and packs them little-endian into Keccak rate blocks.
- Applies SHA-3 domain padding (0x06 … 0x80) to the final block.
- Hands each completed block to the Keccak permutation core over a valid/ready handshake.

---
 rtl/sha3_pkg.sv | 27 ++
 rtl/sha3_blkreg.sv | 73 +++++++
 rtl/sha3_absorb_pack.sv | 171 +++++++++++++++++
 tb/tb_sha3_absorb_pack.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// ---------------------------------------------------------------------------
// sha3_pkg
// Shared definitions for the SHA-3 absorb path: rate sizes per variant (in
// 32-bit words), the SHA-3 domain/end padding bytes and the state encoding of
// the absorb/pack controller.
// ---------------------------------------------------------------------------
package sha3_pkg;

   // Rate in 32-bit words for each SHA-3 variant.
   localparam int RATEW_224 = 36;
   localparam int RATEW_256 = 34;
   localparam int RATEW_384 = 26;
   localparam int RATEW_512 = 18;

   // Domain-separation byte at the message end, and the final-byte marker.
   localparam logic [7:0] PAD_DS  = 8'h06;
   localparam logic [7:0] PAD_END = 8'h80;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      PAD,
      OUT
   } state_t;

endpackage

// File: rtl/sha3_blkreg.sv
// ---------------------------------------------------------------------------
// sha3_blkreg
// RATEW-word Keccak rate block register. Words are written little-endian
// (word i occupies bytes 4i..4i+3) with a per-byte keep mask so a partial
// final word only contributes its message bytes. A single pad strobe XORs the
// domain byte at padpos and the end marker into the last byte of the block.
//
// Ports:
//   clk, rst  clock, synchronous active-high reset (clears the block)
//   clr       clear the whole block to zero
//   wen       write wdata (masked by wkeep) into word widx
//   widx      word index
//   wdata     word data from the FIFO
//   wkeep     per-byte keep mask for wdata (bit b keeps byte b)
//   padx      apply padding: byte padpos ^= 0x06, last byte ^= 0x80
//   padpos    byte offset of the domain-separation byte
//   blk       block contents; byte i = blk[8i+7:8i]
// ---------------------------------------------------------------------------
module sha3_blkreg
   import sha3_pkg::*;
#(
   parameter  int WID   = 32,
   parameter  int RATEW = RATEW_256,
   localparam int WIW   = $clog2(RATEW + 1),
   localparam int PW    = $clog2(RATEW * WID / 8)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 wen,
   input  logic [WIW-1:0]       widx,
   input  logic [WID-1:0]       wdata,
   input  logic [WID/8-1:0]     wkeep,
   input  logic                 padx,
   input  logic [PW-1:0]        padpos,
   output logic [RATEW*WID-1:0] blk
);

   localparam int NBYTE = RATEW * WID / 8;

   logic [WID-1:0]       wmask;
   logic [RATEW*WID-1:0] padvec;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      wmask = '0;
      for (int b = 0; b < WID / 8; b++) begin
         wmask[8*b +: 8] = {8{wkeep[b]}};
      end
   end

   // Both pad bytes are XORed so that padpos == NBYTE-1 yields 0x86.
   always_comb begin
      padvec = '0;
      padvec[8*padpos +: 8] = PAD_DS;
      padvec[8*(NBYTE-1) +: 8] = padvec[8*(NBYTE-1) +: 8] ^ PAD_END;
   end

   // NOTE: the block register is reset even though it is storage, because the
   // block output is visible on the port and must read zero after reset.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         blk <= '0;
      end else if (wen) begin
         blk[WID*int'(widx) +: WID] <= wdata & wmask;
      end else if (padx) begin
         blk <= blk ^ padvec;
      end
   end

endmodule

// File: rtl/sha3_absorb_pack.sv
// ---------------------------------------------------------------------------
// sha3_absorb_pack
// Read-side consumer of the message FIFO. Pulls 32-bit words one at a time,
// packs them little-endian into Keccak rate blocks, applies SHA-3 padding to
// the final block and offers each block to the permutation core over a
// valid/ready handshake.
//
// Ports:
//   clk, rst   FIFO read clock, synchronous active-high reset
//   start      command pulse, accepted only while idle
//   msglen     message length in bytes, sampled on accepted start
//   busy       high from accepted start until the last block is taken
//   fifordy    FIFO holds at least one word
//   fifoget    one-cycle read request (at most one outstanding)
//   fifovld    read data valid, one or more cycles after fifoget
//   fifodout   read data
//   blkvld     block valid
//   blkrdy     permutation core accepts the block
//   blkdo      block data, byte i = blkdo[8i+7:8i]
//   blklast    current block is the final padded block
//   unexperr   one-cycle pulse when fifovld arrives with no get outstanding
// ---------------------------------------------------------------------------
module sha3_absorb_pack
   import sha3_pkg::*;
#(
   parameter int WID   = 32,
   parameter int RATEW = RATEW_256,
   parameter int LENW  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LENW-1:0]      msglen,
   output logic                 busy,
   input  logic                 fifordy,
   output logic                 fifoget,
   input  logic                 fifovld,
   input  logic [WID-1:0]       fifodout,
   output logic                 blkvld,
   input  logic                 blkrdy,
   output logic [RATEW*WID-1:0] blkdo,
   output logic                 blklast,
   output logic                 unexperr
);

   localparam int BW    = WID / 8;
   localparam int TW    = $clog2(BW + 1);
   localparam int NBYTE = RATEW * BW;
   localparam int WIW   = $clog2(RATEW + 1);
   localparam int BCW   = $clog2(NBYTE + 1);
   localparam int PW    = $clog2(NBYTE);
   localparam logic [BCW-1:0] BLKBYTES = BCW'(NBYTE);

   state_t          state;
   logic [LENW-1:0] rem;    // message bytes still to be fetched
   logic [WIW-1:0]  wi;     // next word slot in the block
   logic [BCW-1:0]  bcnt;   // message bytes already in the block

   logic [TW-1:0]   take;   // bytes the current word contributes
   logic [BW-1:0]   keep;
   logic [BCW-1:0]  nbcnt;
   logic [LENW-1:0] nrem;
   logic            wen, clr, padx;

   always_comb begin
      take  = (rem >= LENW'(BW)) ? TW'(BW) : TW'(rem);
      nbcnt = bcnt + BCW'(take);
      nrem  = rem - LENW'(take);
      keep  = '0;
      for (int b = 0; b < BW; b++) begin
         keep[b] = (TW'(b) < take);
      end
   end

   assign wen  = (state == WAIT) && fifovld;
   assign clr  = ((state == IDLE) && start) ||
                 ((state == OUT) && blkrdy && !blklast);
   assign padx = (state == PAD);

   sha3_blkreg #(
      .WID   (WID),
      .RATEW (RATEW)
   ) u_blkreg (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .wen    (wen),
      .widx   (wi),
      .wdata  (fifodout),
      .wkeep  (keep),
      .padx   (padx),
      .padpos (PW'(bcnt)),
      .blk    (blkdo)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rem      <= '0;
         wi       <= '0;
         bcnt     <= '0;
         busy     <= 1'b0;
         fifoget  <= 1'b0;
         blkvld   <= 1'b0;
         blklast  <= 1'b0;
         unexperr <= 1'b0;
      end else begin
         fifoget  <= 1'b0;
         // Only WAIT has a get outstanding; data anywhere else is dropped.
         unexperr <= fifovld && (state != WAIT);
         case (state)
            IDLE: begin
               if (start) begin
                  rem   <= msglen;
                  wi    <= '0;
                  bcnt  <= '0;
                  busy  <= 1'b1;
                  state <= (msglen != '0) ? FETCH : PAD;
               end
            end
            FETCH: begin
               if (fifordy) begin
                  fifoget <= 1'b1;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (fifovld) begin
                  rem  <= nrem;
                  wi   <= wi + WIW'(1);
                  bcnt <= nbcnt;
                  // A partial last word never fills the block, so it pads
                  // in place; a block filled by whole words is sent unpadded.
                  if (nbcnt == BLKBYTES) begin
                     blkvld  <= 1'b1;
                     blklast <= 1'b0;
                     state   <= OUT;
                  end else if (nrem == '0) begin
                     state <= PAD;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            PAD: begin
               blklast <= 1'b1;
               blkvld  <= 1'b1;
               state   <= OUT;
            end
            OUT: begin
               if (blkrdy) begin
                  blkvld <= 1'b0;
                  if (blklast) begin
                     blklast <= 1'b0;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     // rem == 0 here means the message filled whole blocks;
                     // an all-padding block follows.
                     wi    <= '0;
                     bcnt  <= '0;
                     state <= (rem != '0) ? FETCH : PAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha3_absorb_pack.sv
// ---------------------------------------------------------------------------
// tb_sha3_absorb_pack
// Self-checking bench for sha3_absorb_pack (SHA3-256 rate). A FIFO model
// answers gets with variable latency; expected blocks are pushed to a
// scoreboard when a message is launched and compared whenever blkvld is high.
// ---------------------------------------------------------------------------
module tb_sha3_absorb_pack;

   localparam int WID   = 32;
   localparam int RATEW = 34;
   localparam int LENW  = 32;
   localparam int NB    = RATEW * WID / 8;
   localparam int BLKW  = RATEW * WID;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [LENW-1:0] msglen;
   logic            busy;
   logic            fifordy;
   logic            fifoget;
   logic            fifovld;
   logic [WID-1:0]  fifodout;
   logic            blkvld;
   logic            blkrdy;
   logic [BLKW-1:0] blkdo;
   logic            blklast;
   logic            unexperr;

   typedef struct packed {
      logic [BLKW-1:0] data;
      logic            last;
   } exp_blk_t;

   exp_blk_t       sb[$];
   logic [WID-1:0] fifo_q[$];

   int nvec = 0;
   int nerr = 0;
   int get_cnt = 0;
   int unexp_cnt = 0;
   int blk_cnt = 0;
   int vld_cycles = 0;
   int last_vld_cycles = 0;
   int stall_cnt = 0;
   int fixed_extra = -1;
   bit rdy_rand = 1'b1;
   bit inject_vld = 1'b0;
   bit chk_idle_after = 1'b0;

   always #5 clk = ~clk;

   sha3_absorb_pack #(
      .WID   (WID),
      .RATEW (RATEW),
      .LENW  (LENW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .msglen   (msglen),
      .busy     (busy),
      .fifordy  (fifordy),
      .fifoget  (fifoget),
      .fifovld  (fifovld),
      .fifodout (fifodout),
      .blkvld   (blkvld),
      .blkrdy   (blkrdy),
      .blkdo    (blkdo),
      .blklast  (blklast),
      .unexperr (unexperr)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // FIFO model: each get pops one word and returns it 1..3 cycles later.
   bit             get_seen;
   int             lat_cnt = 0;
   logic [WID-1:0] pend = '0;

   initial begin
      fifovld  = 1'b0;
      fifodout = '0;
      fifordy  = 1'b0;
      forever begin
         @(negedge clk);
         get_seen = fifoget;
         @(posedge clk);
         #1;
         fifovld = 1'b0;
         if (get_seen) begin
            if (fifo_q.size() > 0) pend = fifo_q.pop_front();
            else pend = '0;
            lat_cnt = 1 + ((fixed_extra >= 0) ? fixed_extra : int'($urandom_range(0, 2)));
         end
         if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
               fifovld  = 1'b1;
               fifodout = pend;
            end
         end else if (inject_vld) begin
            fifovld    = 1'b1;
            fifodout   = 32'hDEAD_BEEF;
            inject_vld = 1'b0;
         end
         fifordy = (fifo_q.size() > 0);
      end
   end

   // Permutation-core ready: optional forced stall, then random or always-on.
   initial begin
      blkrdy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (blkvld && stall_cnt > 0) begin
            stall_cnt--;
            blkrdy = 1'b0;
         end else if (rdy_rand) begin
            blkrdy = ($urandom_range(0, 3) != 0);
         end else begin
            blkrdy = 1'b1;
         end
      end
   end

   // Output monitor and scoreboard compare, sampled on the falling edge.
   exp_blk_t cur;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (fifoget) get_cnt++;
            if (unexperr) unexp_cnt++;
            if (chk_idle_after) begin
               chk_idle_after = 1'b0;
               check("busy_after_last", busy, 0);
               check("vld_after_last", blkvld, 0);
            end
            if (blkvld) begin
               vld_cycles++;
               check("get_in_out", fifoget, 0);
               if (sb.size() == 0) begin
                  check("unexp_blk", blkvld, 0);
               end else begin
                  cur = sb[0];
                  for (int i = 0; i < RATEW; i++) begin
                     check($sformatf("blk%0d_w%0d", blk_cnt, i),
                           blkdo[WID*i +: WID], cur.data[WID*i +: WID]);
                  end
                  check("blklast", blklast, cur.last);
                  if (blkrdy) begin
                     last_vld_cycles = vld_cycles;
                     vld_cycles = 0;
                     if (cur.last) chk_idle_after = 1'b1;
                     void'(sb.pop_front());
                     blk_cnt++;
                  end
               end
            end
         end
      end
   end

   // Build the message, load the FIFO model and scoreboard, run to completion.
   task automatic run_msg(input int len, input int pat, input int stall);
      logic [7:0]     msg[];
      logic [WID-1:0] w;
      exp_blk_t       e;
      int             nw, nblk, g0, u0, b0, idx, p;
      bit             done;
      msg = new[len];
      for (int i = 0; i < len; i++) begin
         case (pat)
            0:       msg[i] = 8'(8'h61 + i);
            1:       msg[i] = 8'h11;
            default: msg[i] = 8'($urandom);
         endcase
      end
      nw = (len + 3) / 4;
      for (int k = 0; k < nw; k++) begin
         w = '0;
         for (int b = 0; b < 4; b++) begin
            idx = 4 * k + b;
            w[8*b +: 8] = (idx < len) ? msg[idx] : 8'hAA;
         end
         fifo_q.push_back(w);
      end
      nblk = len / NB + 1;
      for (int bk = 0; bk < nblk; bk++) begin
         e.data = '0;
         e.last = (bk == nblk - 1);
         for (int j = 0; j < NB; j++) begin
            if (bk * NB + j < len) e.data[8*j +: 8] = msg[bk * NB + j];
         end
         if (e.last) begin
            p = len % NB;
            e.data[8*p +: 8]      = e.data[8*p +: 8] ^ 8'h06;
            e.data[8*(NB-1) +: 8] = e.data[8*(NB-1) +: 8] ^ 8'h80;
         end
         sb.push_back(e);
      end
      stall_cnt = stall;
      rdy_rand  = (stall == 0);
      g0 = get_cnt;
      u0 = unexp_cnt;
      b0 = blk_cnt;
      @(posedge clk);
      #1;
      start  = 1'b1;
      msglen = LENW'(len);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check($sformatf("busy_rise_len%0d", len), busy, 1);
      done = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (!busy && sb.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      check($sformatf("done_len%0d", len), done, 1);
      check($sformatf("gets_len%0d", len), get_cnt - g0, nw);
      check($sformatf("blocks_len%0d", len), blk_cnt - b0, nblk);
      check($sformatf("unexp_len%0d", len), unexp_cnt - u0, 0);
      if (!done) begin
         sb.delete();
         fifo_q.delete();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int  u0, g0;
   bit  seen;

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      msglen = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_fifoget", fifoget, 0);
      check("rst_blkvld", blkvld, 0);
      check("rst_blklast", blklast, 0);
      check("rst_blkdo", |blkdo, 0);
      check("rst_busy", busy, 0);
      check("rst_unexperr", unexperr, 0);

      run_msg(0, 0, 0);
      run_msg(3, 0, 0);
      run_msg(135, 1, 0);
      run_msg(136, 2, 0);
      run_msg(8, 2, 5);
      check("stall_vld_cycles", last_vld_cycles, 6);

      // Stray data while idle.
      u0 = unexp_cnt;
      g0 = get_cnt;
      inject_vld = 1'b1;
      repeat (6) @(negedge clk);
      check("idle_unexp_cycles", unexp_cnt - u0, 1);
      check("idle_busy", busy, 0);
      check("idle_blkvld", blkvld, 0);
      check("idle_gets", get_cnt - g0, 0);

      // Reset while waiting for a word; the late word must flag unexperr.
      rdy_rand    = 1'b1;
      fixed_extra = 3;
      fifo_q.push_back(32'h0403_0201);
      fifo_q.push_back(32'h0807_0605);
      u0 = unexp_cnt;
      @(posedge clk);
      #1;
      start  = 1'b1;
      msglen = 8;
      @(posedge clk);
      #1;
      start = 1'b0;
      seen  = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (fifoget) begin
            seen = 1'b1;
            break;
         end
      end
      check("wait_get_seen", seen, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      fifo_q.delete();
      @(negedge clk);
      check("mid_rst_fifoget", fifoget, 0);
      check("mid_rst_blkvld", blkvld, 0);
      check("mid_rst_blklast", blklast, 0);
      check("mid_rst_blkdo", |blkdo, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_unexperr", unexperr, 0);
      repeat (8) @(negedge clk);
      check("late_word_unexp", unexp_cnt - u0, 1);
      fixed_extra = -1;
      fifo_q.delete();

      run_msg(4, 2, 0);
      run_msg(300, 2, 0);
      run_msg(272, 2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
